// File: rtl/filtro_temperatura.sv
// Sensor input conditioning: range check, power-of-two moving average, and fault
// detection on a missing-sample timeout or repeated out-of-range samples.
module filtro_temperatura #(
  parameter int ANCHO      = 10,
  parameter int LOG2_N     = 2,
  parameter int TEMP_MIN   = 0,
  parameter int TEMP_MAX   = 1000,
  parameter int TIMEOUT    = 64,
  parameter int MAX_FUERA  = 3,
  parameter int TEMP_RESET = 220
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic [ANCHO-1:0] muestra_in,
  input  logic             muestra_valida,
  output logic [ANCHO-1:0] temp_filtrada,
  output logic             temp_valida,
  output logic             falla_sensor,
  output logic [1:0]       estado_filtro
);

  localparam int N  = 1 << LOG2_N;
  localparam int SW = ANCHO + LOG2_N;
  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int FW = $clog2(MAX_FUERA) + 1;
  localparam int CW = LOG2_N + 1;

  localparam logic [1:0] LLENADO   = 2'b00;
  localparam logic [1:0] FILTRANDO = 2'b01;
  localparam logic [1:0] FALLA     = 2'b10;

  logic [1:0]       state_q, state_d;
  logic [ANCHO-1:0] buf_q [N];
  logic [LOG2_N-1:0] ptr_q, ptr_d, wr_idx;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [SW-1:0]    suma_q, suma_d, suma_nxt;
  logic [WW-1:0]    wdog_q, wdog_d;
  logic [FW-1:0]    fuera_q, fuera_d;
  logic [ANCHO-1:0] temp_q, temp_d, viejo;
  logic             valid_q, valid_d, wr_en, en_rango;

  // Signed compare keeps a zero lower bound from being a constant-true test.
  assign en_rango = (int'(muestra_in) >= TEMP_MIN) && (int'(muestra_in) <= TEMP_MAX);
  // Slots not yet written since the last flush count as zero.
  assign viejo    = (cnt_q == CW'(N)) ? buf_q[ptr_q] : '0;
  assign suma_nxt = suma_q + SW'(muestra_in) - SW'(viejo);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    suma_d  = suma_q;
    wdog_d  = wdog_q;
    fuera_d = fuera_q;
    temp_d  = temp_q;
    valid_d = 1'b0;
    wr_en   = 1'b0;
    wr_idx  = ptr_q;
    if (state_q == FALLA) begin
      if (muestra_valida && en_rango) begin
        state_d = LLENADO;
        wr_en   = 1'b1;
        wr_idx  = '0;
        suma_d  = SW'(muestra_in);
        ptr_d   = LOG2_N'(1);
        cnt_d   = CW'(1);
        wdog_d  = '0;
        fuera_d = '0;
      end
    end else if (muestra_valida) begin
      wdog_d = '0;
      if (en_rango) begin
        fuera_d = '0;
        wr_en   = 1'b1;
        suma_d  = suma_nxt;
        ptr_d   = ptr_q + 1'b1;
        if (cnt_q != CW'(N)) cnt_d = cnt_q + 1'b1;
        if (state_q == FILTRANDO || cnt_q == CW'(N-1)) begin
          state_d = FILTRANDO;
          temp_d  = suma_nxt[SW-1:LOG2_N];
          valid_d = 1'b1;
        end
      end else if (fuera_q == FW'(MAX_FUERA-1)) begin
        state_d = FALLA;
        fuera_d = '0;
      end else begin
        fuera_d = fuera_q + 1'b1;
      end
    end else if (wdog_q == WW'(TIMEOUT-1)) begin
      state_d = FALLA;
    end else begin
      wdog_d = wdog_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= LLENADO;
      ptr_q   <= '0;
      cnt_q   <= '0;
      suma_q  <= '0;
      wdog_q  <= '0;
      fuera_q <= '0;
      temp_q  <= ANCHO'(TEMP_RESET);
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      suma_q  <= suma_d;
      wdog_q  <= wdog_d;
      fuera_q <= fuera_d;
      temp_q  <= temp_d;
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < N; i++) buf_q[i] <= '0;
    end else if (wr_en) begin
      buf_q[wr_idx] <= muestra_in;
    end
  end

  assign temp_filtrada = temp_q;
  assign temp_valida   = valid_q;
  assign falla_sensor  = (state_q == FALLA);
  assign estado_filtro = state_q;

endmodule

// File: tb/tb_filtro_temperatura.sv
// Directed bench for filtro_temperatura: fill/average, truncation, timeout,
// out-of-range fault, recovery, range boundaries and asynchronous reset.
module tb_filtro_temperatura;

  logic       clk = 1'b0;
  logic       arst_n;
  logic [9:0] muestra_in;
  logic       muestra_valida;
  logic [9:0] temp_filtrada;
  logic       temp_valida;
  logic       falla_sensor;
  logic [1:0] estado_filtro;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  filtro_temperatura dut (
    .clk           (clk),
    .arst_n        (arst_n),
    .muestra_in    (muestra_in),
    .muestra_valida(muestra_valida),
    .temp_filtrada (temp_filtrada),
    .temp_valida   (temp_valida),
    .falla_sensor  (falla_sensor),
    .estado_filtro (estado_filtro)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // temp / valid / fault / state in one go
  task automatic chk_all(input string tag, input int t, input int v, input int f, input int e);
    chk({tag, ".temp"},  32'(temp_filtrada), 32'(t));
    chk({tag, ".valid"}, 32'(temp_valida),   32'(v));
    chk({tag, ".falla"}, 32'(falla_sensor),  32'(f));
    chk({tag, ".estado"},32'(estado_filtro), 32'(e));
  endtask

  // Strobe one sample; consecutive calls give back-to-back strobes.
  task automatic strobe(input int v);
    @(negedge clk);
    muestra_in     = 10'(v);
    muestra_valida = 1'b1;
    @(posedge clk);
    #1;
    muestra_valida = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    arst_n         = 1'b0;
    muestra_in     = '0;
    muestra_valida = 1'b0;
    #12;
    chk_all("reset", 220, 0, 0, 0);
    @(negedge clk);
    arst_n = 1'b1;

    // Fill with 200s: no pulse until the fourth sample.
    strobe(200); chk_all("fill1", 220, 0, 0, 0);
    strobe(200); chk_all("fill2", 220, 0, 0, 0);
    strobe(200); chk_all("fill3", 220, 0, 0, 0);
    strobe(200); chk_all("fill4", 200, 1, 0, 1);
    idle(1);     chk("pulse_one_cycle", 32'(temp_valida), 0);
    strobe(240); chk_all("avg240", 210, 1, 0, 1);

    // Sums: 841, 842, 843, 805 (240 leaves), then 806, 807, 808.
    strobe(201); chk("tr_a", 32'(temp_filtrada), 210);
    strobe(201);
    strobe(201); chk("tr_b", 32'(temp_filtrada), 210);
    strobe(202); chk_all("trunc805", 201, 1, 0, 1);
    strobe(202); chk("trunc806", 32'(temp_filtrada), 201);
    strobe(202); chk("trunc807", 32'(temp_filtrada), 201);
    strobe(202); chk("trunc808", 32'(temp_filtrada), 202);

    // Steady 220, then a strobe lands exactly at the last watchdog cycle.
    repeat (4) strobe(220);
    chk_all("steady220", 220, 1, 0, 1);
    idle(63);    chk("wd63_nofault", 32'(falla_sensor), 0);
    strobe(220); chk_all("wd_strobe_wins", 220, 1, 0, 1);
    idle(63);    chk("wd_edge63", 32'(falla_sensor), 0);
    idle(1);     chk_all("timeout_fault", 220, 0, 1, 2);

    // Recovery: out-of-range ignored, first in-range sample flushes.
    strobe(1023); chk_all("falla_ignores_oor", 220, 0, 1, 2);
    strobe(180);  chk_all("recover", 220, 0, 0, 0);
    strobe(180);
    strobe(180);  chk_all("refill3", 220, 0, 0, 0);
    strobe(180);  chk_all("refill4", 180, 1, 0, 1);

    // Two out-of-range then in-range: count resets, 720-180+220=760 -> 190.
    strobe(1023); chk_all("oor1", 180, 0, 0, 1);
    strobe(1023); chk("oor2_nofault", 32'(falla_sensor), 0);
    strobe(220);  chk_all("oor_reset_cnt", 190, 1, 0, 1);
    strobe(1023);
    strobe(1023); chk("oor2b", 32'(falla_sensor), 0);
    strobe(1023); chk_all("oor3_fault", 190, 0, 1, 2);

    // Range boundaries: 1001 rejected, 1000 and 0 accepted; (1000+0+0+0)>>2.
    strobe(1001); chk_all("max_plus1", 190, 0, 1, 2);
    strobe(1000); chk_all("max_inclusive", 190, 0, 0, 0);
    strobe(0);
    strobe(0);
    strobe(0);    chk_all("min_inclusive", 250, 1, 0, 1);

    // Async reset with no clock edge involved.
    #1 arst_n = 1'b0;
    #1 chk_all("async_rst_a", 220, 0, 0, 0);
    @(negedge clk);
    arst_n = 1'b1;
    strobe(500);
    strobe(500);
    #2 arst_n = 1'b0;
    #1 chk_all("async_rst_midfill", 220, 0, 0, 0);
    @(posedge clk);
    #3 arst_n = 1'b1;
    strobe(300); chk_all("post_rst1", 220, 0, 0, 0);
    strobe(300);
    strobe(300); chk_all("post_rst3", 220, 0, 0, 0);
    strobe(300); chk_all("post_rst4", 300, 1, 0, 1);
    idle(1);     chk("post_rst_pulse_end", 32'(temp_valida), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
